key_debounce_timer: RTL and testbench

Debounces one mechanical push-key and measures its press timing against the millisecond system time. It sits directly downstream of the clock divider and consumes `system_time_ms`, the free-running millisecond count. It runs entirely on `clk_in` and does not use any divided clock as a clock. It produces clean press/release events, a press timestamp and a hold duration for the control logic.

---
 rtl/key_debounce_timer.sv | 134 +++++++++++++
 tb/tb_key_debounce_timer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_timer.sv
// rtl/key_debounce_timer.sv - key debouncer with press timestamp and hold-duration timer
// Define KEY_LONG_PRESS_EN to enable the long_press strobe at LONG_MS of hold.
`timescale 1ns/1ps
module key_debounce_timer #(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int HOLD_W      = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [31:0]       system_time_ms,
  input  logic              key_in,
  output logic              key_pressed,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic [31:0]       press_time_ms,
  output logic [HOLD_W-1:0] hold_ms,
  output logic              long_press
);
  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, RELEASE_DB} state_t;

`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam logic [7:0]        DB_LIMIT   = 8'(DEBOUNCE_MS);
  localparam logic [HOLD_W-1:0] LONG_LIMIT = HOLD_W'(LONG_MS);

  state_t            state;
  logic              sync1, sync2, key_s;
  logic [31:0]       prev_ms;
  logic              valid, ms_tick;
  logic [7:0]        db_cnt, db_next;
  logic              hold_sat, long_hit;
  logic [HOLD_W-1:0] hold_next;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign key_s = ~sync2;

  // valid suppresses a false tick on the first clock after reset
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      prev_ms <= '0;
      valid   <= 1'b0;
    end else begin
      prev_ms <= system_time_ms;
      valid   <= 1'b1;
    end
  end

  assign ms_tick   = valid && (system_time_ms != prev_ms);
  assign db_next   = db_cnt + 8'd1;
  assign hold_sat  = &hold_ms;
  assign hold_next = hold_sat ? hold_ms : hold_ms + HOLD_W'(1);
  assign long_hit  = LONG_EN && ms_tick && !hold_sat && (hold_next == LONG_LIMIT);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      key_pressed   <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_time_ms <= '0;
      hold_ms       <= '0;
      long_press    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      case (state)
        IDLE: begin
          if (key_s) begin
            state  <= PRESS_DB;
            db_cnt <= '0;
          end
        end
        PRESS_DB: begin
          if (!key_s) begin
            state <= IDLE;
          end else if (ms_tick) begin
            db_cnt <= db_next;
            if (db_next == DB_LIMIT) begin
              state         <= PRESSED;
              key_pressed   <= 1'b1;
              press_pulse   <= 1'b1;
              press_time_ms <= system_time_ms;
              hold_ms       <= '0;
            end
          end
        end
        PRESSED: begin
          if (ms_tick) begin
            hold_ms    <= hold_next;
            long_press <= long_hit;
          end
          if (!key_s) begin
            state  <= RELEASE_DB;
            db_cnt <= '0;
          end
        end
        RELEASE_DB: begin
          // hold keeps running while the release is still unconfirmed
          if (ms_tick) begin
            hold_ms    <= hold_next;
            long_press <= long_hit;
          end
          if (key_s) begin
            state <= PRESSED;
          end else if (ms_tick) begin
            db_cnt <= db_next;
            if (db_next == DB_LIMIT) begin
              state         <= IDLE;
              key_pressed   <= 1'b0;
              release_pulse <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_debounce_timer.sv
// tb/tb_key_debounce_timer.sv - randomized bench for key_debounce_timer against a level/tick model
`timescale 1ns/1ps
module tb_key_debounce_timer;
  localparam int DB       = 3;
  localparam int LONG     = 20;
  localparam int HW       = 16;
  localparam int HOLD_MAX = (1 << HW) - 1;
`ifdef KEY_LONG_PRESS_EN
  localparam bit MODEL_LONG = 1'b1;
`else
  localparam bit MODEL_LONG = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   system_time_ms = 32'd0;
  logic          key_in = 1'b1;
  logic          key_pressed, press_pulse, release_pulse, long_press;
  logic [31:0]   press_time_ms;
  logic [HW-1:0] hold_ms;

  key_debounce_timer #(.DEBOUNCE_MS(DB), .LONG_MS(LONG), .HOLD_W(HW)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .system_time_ms(system_time_ms), .key_in(key_in),
    .key_pressed(key_pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .press_time_ms(press_time_ms), .hold_ms(hold_ms), .long_press(long_press)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int period = 10;
  int div = 0;
  int n_press = 0, n_release = 0, n_long = 0;

  // reference: debounced level plus count of ms ticks seen while the raw level disagrees
  bit          m_s1, m_s2, m_valid, m_deb, m_run;
  bit          m_press, m_rel, m_long;
  logic [31:0] m_prev, m_ptime;
  int          m_cnt, m_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_valid = 0; m_prev = 0; m_deb = 0; m_run = 0; m_cnt = 0;
    m_hold = 0; m_ptime = 0; m_press = 0; m_rel = 0; m_long = 0;
  endtask

  task automatic model_edge();
    bit tick, ks;
    tick = m_valid && (system_time_ms != m_prev);
    ks = !m_s2;
    m_press = 0; m_rel = 0; m_long = 0;
    if (m_deb && tick && m_hold < HOLD_MAX) begin
      m_hold++;
      if (MODEL_LONG && m_hold == LONG) m_long = 1;
    end
    if (ks == m_deb) begin
      m_run = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_cnt = 0;
    end else if (tick) begin
      m_cnt++;
      if (m_cnt == DB) begin
        m_run = 0;
        m_deb = ks;
        if (ks) begin
          m_press = 1;
          m_ptime = system_time_ms;
          m_hold = 0;
        end else begin
          m_rel = 1;
        end
      end
    end
    m_prev = system_time_ms;
    m_valid = 1;
    m_s2 = m_s1;
    m_s1 = key_in;
  endtask

  task automatic compare_all();
    check("key_pressed", key_pressed, m_deb);
    check("press_pulse", press_pulse, m_press);
    check("release_pulse", release_pulse, m_rel);
    check("press_time_ms", press_time_ms, m_ptime);
    check("hold_ms", hold_ms, 32'(m_hold));
    check("long_press", long_press, m_long);
    check("pulse_excl", press_pulse & release_pulse, 0);
  endtask

  task automatic step();
    @(posedge clk_in);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    compare_all();
    if (press_pulse === 1'b1) n_press++;
    if (release_pulse === 1'b1) n_release++;
    if (long_press === 1'b1) n_long++;
    div++;
    if (div >= period) begin
      div = 0;
      system_time_ms = system_time_ms + 32'd1;
    end
  endtask

  task automatic run(input int n, input bit k);
    key_in = k;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int bp, br, bl;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    run(20, 1'b1);

    // clean press then release
    bp = n_press; br = n_release;
    run(100, 1'b0);
    check("clean_press_cnt", n_press - bp, 1);
    check("clean_key_pressed", key_pressed, 1);
    check("clean_press_time", press_time_ms, m_ptime);
    run(100, 1'b1);
    check("clean_release_cnt", n_release - br, 1);

    // bounce every 4 cycles: never stable long enough
    bp = n_press; br = n_release;
    for (int i = 0; i < 15; i++) run(4, i[0]);
    run(60, 1'b1);
    check("bounce_press_cnt", n_press - bp, 0);
    check("bounce_release_cnt", n_release - br, 0);
    check("bounce_key_pressed", key_pressed, 0);

    // 50 ms hold then release; hold value must persist in IDLE
    run(500, 1'b0);
    run(100, 1'b1);
    check("hold_key_pressed", key_pressed, 0);
    check("hold_idle", hold_ms, 32'(m_hold));
    run(50, 1'b1);
    check("hold_persist", hold_ms, 32'(m_hold));

    // 40 ms hold crosses LONG
    bl = n_long;
    run(400, 1'b0);
    run(100, 1'b1);
    check("long_cnt", n_long - bl, MODEL_LONG ? 1 : 0);

    // randomized key activity and tick rates
    for (int i = 0; i < 40; i++) begin
      period = $urandom_range(1, 12);
      run($urandom_range(1, 80), 1'($urandom_range(0, 1)));
    end
    period = 10;
    run(100, 1'b1);

    // timestamp wrap, then reset while pressed
    div = 0;
    system_time_ms = 32'hFFFF_FFFE;
    bp = n_press;
    run(60, 1'b0);
    check("wrap_press_cnt", n_press - bp, 1);
    check("wrap_press_time", press_time_ms, m_ptime);
    check("wrap_key_pressed", key_pressed, 1);

    br = n_release; bp = n_press;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_key_pressed", key_pressed, 0);
    check("rst_press_time", press_time_ms, 0);
    check("rst_hold", hold_ms, 0);
    check("rst_pulses", {long_press, press_pulse, release_pulse}, 0);
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b1;
    run(60, 1'b0);
    check("rst_no_release", n_release - br, 0);
    check("rst_repress_cnt", n_press - bp, 1);
    run(60, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
